// File: rtl/softmax_seq.sv
// softmax_seq
//   Sequencer for the classifier's softmax stage. It buffers N_CLASSES
//   single-precision scores and streams each one through an external exp
//   unit while accumulating the sum on an external adder. It then divides
//   each exp value by that sum on an external divider and streams the
//   probabilities out with a valid/ready handshake. The controller never
//   looks at the data, so FP special values pass through untouched.
//
// Ports
//   clock_i      clock, all state on the rising edge
//   reset_ni     asynchronous active-low reset
//   in_data_i    score word                  in_valid_i / in_ready_o handshake
//   exp_in_o     operand to exp unit         exp_out_i  e^exp_in_o, EXP_LAT cycles later
//   add_a_o      running sum                 add_b_o    exp value being accumulated
//   add_y_i      add_a_o + add_b_o, combinational
//   div_a_o      buffered exp value          div_b_o    final sum
//   div_y_i      div_a_o / div_b_o, DIV_LAT cycles later
//   out_data_o   probability                 out_valid_o / out_ready_i handshake
//   out_last_o   qualifies the last class of an inference
//   busy_o       high whenever the block is not accepting scores
module softmax_seq #(
  parameter int datawidth = 32,
  parameter int N_CLASSES = 10,
  parameter int EXP_LAT   = 1,
  parameter int DIV_LAT   = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic [datawidth-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [datawidth-1:0] exp_in_o,
  input  logic [datawidth-1:0] exp_out_i,
  output logic [datawidth-1:0] add_a_o,
  output logic [datawidth-1:0] add_b_o,
  input  logic [datawidth-1:0] add_y_i,
  output logic [datawidth-1:0] div_a_o,
  output logic [datawidth-1:0] div_b_o,
  input  logic [datawidth-1:0] div_y_i,
  output logic [datawidth-1:0] out_data_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  localparam int            IW       = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CLASSES - 1);
  localparam logic [7:0]    EXP_CNT  = 8'(EXP_LAT);
  localparam logic [7:0]    DIV_CNT  = 8'(DIV_LAT);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           cnt_q;
  logic [datawidth-1:0] sum_q;
  logic [datawidth-1:0] out_data_q;
  // Last value driven on each operand port, so unused operands hold steady.
  logic [datawidth-1:0] exp_in_q, add_a_q, add_b_q, div_a_q, div_b_q;
  // Holds raw scores during LOAD and is overwritten in place by the exp values.
  logic [datawidth-1:0] score_buf_q [N_CLASSES];

  logic [datawidth-1:0] buf_rd;
  logic                 load_acc, exp_cap, div_cap, idx_last;

  assign buf_rd   = score_buf_q[idx_q];
  assign load_acc = (state_q == S_LOAD) && in_valid_i;
  assign exp_cap  = (state_q == S_EXP) && (cnt_q == EXP_CNT);
  assign div_cap  = (state_q == S_DIV) && (cnt_q == DIV_CNT);
  assign idx_last = (idx_q == LAST_IDX);

  // Operands are live only in the state that uses them; with zero-latency
  // units the result must follow the operand in the same cycle.
  assign exp_in_o = (state_q == S_EXP) ? buf_rd    : exp_in_q;
  assign add_a_o  = (state_q == S_EXP) ? sum_q     : add_a_q;
  assign add_b_o  = (state_q == S_EXP) ? exp_out_i : add_b_q;
  assign div_a_o  = (state_q == S_DIV) ? buf_rd    : div_a_q;
  assign div_b_o  = (state_q == S_DIV) ? sum_q     : div_b_q;

  assign in_ready_o  = (state_q == S_LOAD);
  assign busy_o      = (state_q != S_LOAD);
  assign out_valid_o = (state_q == S_OUT);
  assign out_last_o  = (state_q == S_OUT) && idx_last;
  assign out_data_o  = out_data_q;

  // Buffer has no reset: contents are don't-care until written.
  always_ff @(posedge clock_i) begin
    if (load_acc) begin
      score_buf_q[idx_q] <= in_data_i;
    end else if (exp_cap) begin
      score_buf_q[idx_q] <= exp_out_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      out_data_q <= '0;
      exp_in_q   <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
    end else begin
      exp_in_q <= exp_in_o;
      add_a_q  <= add_a_o;
      add_b_q  <= add_b_o;
      div_a_q  <= div_a_o;
      div_b_q  <= div_b_o;
      case (state_q)
        S_LOAD: begin
          if (in_valid_i) begin
            if (idx_last) begin
              idx_q   <= '0;
              cnt_q   <= '0;
              sum_q   <= '0;
              state_q <= S_EXP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_EXP: begin
          if (cnt_q == EXP_CNT) begin
            sum_q <= add_y_i;
            cnt_q <= '0;
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= S_DIV;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DIV: begin
          if (div_cap) begin
            out_data_q <= div_y_i;
            cnt_q      <= '0;
            state_q    <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_DIV;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule
